fifo_packet_vc: RTL and testbench

- Multi-virtual-channel input buffer for a router input port.
- Stores `packet_t` packets in `NUM_VC` independent circular queues, each `DEPTH` entries deep.
- Shows the head of each queue to the switch controller (show-ahead).
- Reports a per-VC free-slot count to the upstream node for credit-based flow control.
- Successor to the single-queue packet FIFO: adds VC count, arbitrary (non-power-of-two) depth and overflow detection.

---
 rtl/fifo_packet_vc_if.sv | 56 +++++
 rtl/fifo_packet_vc.sv | 134 +++++++++++++
 tb/tb_fifo_packet_vc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_packet_vc_if.sv
// -----------------------------------------------------------------------------
// fifo_packet_vc_pkg / fifo_packet_vc_if
//
// Purpose : shared packet type and the bus bundle between a router input
//           port buffer (fifo_packet_vc) and its upstream node / switch
//           controller.
//
// Package : INPUT_QUEUE_DEPTH - default entries per VC queue
//           packet_t          - packet stored in the buffer (id + payload)
//
// Interface signals (names as seen by the buffer):
//   i_data      packet_t                 incoming packet
//   i_data_val  1                        i_data valid this cycle
//   i_vc        VC_W                     target VC of i_data
//   i_en        NUM_VC                   per-VC pop request
//   o_data      NUM_VC x packet_t        head packet of each VC
//   o_data_val  NUM_VC                   head of VC v valid
//   o_free      NUM_VC x CNT_W           free slots per VC
//   o_overflow  1                        sticky overflow flag
//
// Modports: master = upstream/switch side, slave = buffer side.
// -----------------------------------------------------------------------------
package fifo_packet_vc_pkg;
    localparam int INPUT_QUEUE_DEPTH = 5;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] payload;
    } packet_t;
endpackage

interface fifo_packet_vc_if #(
    parameter int DEPTH  = fifo_packet_vc_pkg::INPUT_QUEUE_DEPTH,
    parameter int NUM_VC = 2,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    fifo_packet_vc_pkg::packet_t                          i_data;
    logic                                                 i_data_val;
    logic [VC_W-1:0]                                      i_vc;
    logic [NUM_VC-1:0]                                    i_en;
    fifo_packet_vc_pkg::packet_t [NUM_VC-1:0]             o_data;
    logic [NUM_VC-1:0]                                    o_data_val;
    logic [NUM_VC-1:0][CNT_W-1:0]                         o_free;
    logic                                                 o_overflow;

    modport master (
        output i_data, i_data_val, i_vc, i_en,
        input  o_data, o_data_val, o_free, o_overflow
    );

    modport slave (
        input  i_data, i_data_val, i_vc, i_en,
        output o_data, o_data_val, o_free, o_overflow
    );
endinterface

// File: rtl/fifo_packet_vc.sv
// -----------------------------------------------------------------------------
// fifo_packet_vc
//
// Purpose : multi-virtual-channel input buffer for a router input port.
//           NUM_VC independent circular queues of DEPTH packets each (DEPTH
//           need not be a power of two), show-ahead head view per VC,
//           per-VC free-slot count for credit flow control and a sticky
//           overflow flag.
//
// Ports   : clk      in  rising-edge clock
//           reset_n  in  asynchronous active-low reset
//           ce       in  clock enable; all state holds when low
//           bus      fifo_packet_vc_if.slave (see interface file)
//
// Option  : `define FIFO_VC_BYPASS_EN adds a same-cycle path from i_data to
//           o_data of an empty VC; a packet popped in that cycle is never
//           stored. Without it, minimum latency is one cycle.
// -----------------------------------------------------------------------------
module fifo_packet_vc #(
    parameter int DEPTH  = fifo_packet_vc_pkg::INPUT_QUEUE_DEPTH,
    parameter int NUM_VC = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    fifo_packet_vc_if.slave    bus
);
    import fifo_packet_vc_pkg::*;

    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    packet_t            r_mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr [NUM_VC];
    logic [PTR_W-1:0]   r_rd_ptr [NUM_VC];
    logic [CNT_W-1:0]   r_occ    [NUM_VC];
    logic               r_overflow;

    logic               w_vc_ok;
    logic [NUM_VC-1:0]  w_hit;       // valid write addressed to VC v
    logic [NUM_VC-1:0]  w_pop;       // effective pop (queue non-empty)
    logic [NUM_VC-1:0]  w_accept;    // write has room (or pop frees a slot)
    logic [NUM_VC-1:0]  w_push;      // write lands in memory
    logic [NUM_VC-1:0]  w_byp;       // bypass view active on VC v
    logic               w_ovf_evt;

    // Explicit wrap compare so any DEPTH >= 2 works, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_vc_ok  = 32'(bus.i_vc) < NUM_VC;
        w_hit    = '0;
        w_pop    = '0;
        w_accept = '0;
        w_push   = '0;
        w_byp    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_hit[v]    = bus.i_data_val && w_vc_ok && (32'(bus.i_vc) == v);
            w_pop[v]    = bus.i_en[v] && (r_occ[v] != '0);
            // A full VC still accepts when the same-cycle pop frees a slot.
            w_accept[v] = w_hit[v] && ((r_occ[v] != CNT_W'(DEPTH)) || w_pop[v]);
`ifdef FIFO_VC_BYPASS_EN
            // Gated by ce so outputs stay frozen while the block is stalled.
            w_byp[v]    = ce && w_hit[v] && (r_occ[v] == '0);
            // Bypassed and popped in the same cycle: consumed, never stored.
            w_push[v]   = w_accept[v] && !(w_byp[v] && bus.i_en[v]);
`else
            w_push[v]   = w_accept[v];
`endif
        end
        // Valid write that found no home: bad VC index or full without pop.
        w_ovf_evt = bus.i_data_val && (!w_vc_ok || ((w_hit & ~w_accept) != '0));
    end

    // Head view: registered state only, except for the optional bypass.
    always_comb begin
        bus.o_data     = '0;
        bus.o_data_val = '0;
        bus.o_free     = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            // Empty queues show zero rather than stale memory.
            if (r_occ[v] != '0) begin
                bus.o_data[v]     = r_mem[v][r_rd_ptr[v]];
                bus.o_data_val[v] = 1'b1;
            end
            if (w_byp[v]) begin
                bus.o_data[v]     = bus.i_data;
                bus.o_data_val[v] = 1'b1;
            end
            bus.o_free[v] = CNT_W'(DEPTH) - r_occ[v];
        end
    end

    assign bus.o_overflow = r_overflow;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_occ[v]    <= '0;
            end
            r_overflow <= 1'b0;
        end else if (ce) begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push[v]) r_wr_ptr[v] <= ptr_inc(r_wr_ptr[v]);
                if (w_pop[v])  r_rd_ptr[v] <= ptr_inc(r_rd_ptr[v]);
                if (w_push[v] && !w_pop[v])
                    r_occ[v] <= r_occ[v] + CNT_W'(1);
                else if (!w_push[v] && w_pop[v])
                    r_occ[v] <= r_occ[v] - CNT_W'(1);
            end
            if (w_ovf_evt) r_overflow <= 1'b1;
        end
    end

    // NOTE: the packet store has no reset; occupancy alone decides what is
    // valid, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push[v]) r_mem[v][r_wr_ptr[v]] <= bus.i_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_packet_vc.sv
// -----------------------------------------------------------------------------
// tb_fifo_packet_vc
//
// Directed bench for fifo_packet_vc (DEPTH=5, NUM_VC=2). Stimulus pushes the
// id of every packet it expects the buffer to keep into a per-VC queue; a
// monitor on the falling edge pops that queue and compares whenever the DUT
// presents a valid head that is being popped. Status outputs (o_free,
// o_data_val, o_overflow) are checked directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fifo_packet_vc;
    localparam int DEPTH  = 5;
    localparam int NUM_VC = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [NUM_VC][$];
    logic [7:0] mon_exp;
    int         occ_m [NUM_VC];
    logic       ovf_m;

    fifo_packet_vc_if #(.DEPTH(DEPTH), .NUM_VC(NUM_VC)) bus ();

    fifo_packet_vc #(.DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a popped valid head must match the oldest expected id.
    always @(negedge clk) begin
        if (reset_n && ce) begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (bus.i_en[v] && bus.o_data_val[v]) begin
                    if (exp_q[v].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL vc%0d_pop: got id %0h, expected no packet", v, bus.o_data[v].id);
                    end else begin
                        mon_exp = exp_q[v].pop_front();
                        check($sformatf("vc%0d_head", v), 32'(bus.o_data[v].id), 32'(mon_exp));
                    end
                end
            end
        end
    end

    // One clock: drive inputs, let the edge pass, idle the inputs at edge+1.
    task automatic step(input logic dv, input int vc, input logic [7:0] id,
                        input logic [1:0] en, input logic acc);
        bus.i_data_val = dv;
        bus.i_vc       = vc[0];
        bus.i_data     = {id, 8'hA5, id};
        bus.i_en       = en;
        if (dv && acc) exp_q[vc].push_back(id);
        @(posedge clk);
        #1;
        bus.i_data_val = 1'b0;
        bus.i_en       = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int v = 0; v < NUM_VC; v++) exp_q[v].delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.i_data_val = 1'b0;
        bus.i_vc       = '0;
        bus.i_data     = '0;
        bus.i_en       = '0;
        do_reset();

        // Reset state
        check("rst_val",   32'(bus.o_data_val), 32'h0);
        check("rst_free0", 32'(bus.o_free[0]), DEPTH);
        check("rst_free1", 32'(bus.o_free[1]), DEPTH);
        check("rst_ovf",   32'(bus.o_overflow), 32'h0);
        check("rst_data0", 32'(bus.o_data[0]), 32'h0);

        // Three packets into VC0, no pops
        for (int i = 1; i <= 3; i++) step(1'b1, 0, 8'(i), 2'b00, 1'b1);
        check("w3_free0", 32'(bus.o_free[0]), DEPTH - 3);
        check("w3_head0", 32'(bus.o_data[0].id), 32'd1);
        check("w3_val",   32'(bus.o_data_val), 32'b01);
        check("w3_free1", 32'(bus.o_free[1]), DEPTH);

        // Fill VC1 with ids 10..14
        for (int i = 10; i <= 14; i++) step(1'b1, 1, 8'(i), 2'b00, 1'b1);
        check("full_free1", 32'(bus.o_free[1]), 32'h0);
        check("full_val",   32'(bus.o_data_val), 32'b11);
        check("full_ovf",   32'(bus.o_overflow), 32'h0);

        // Full VC1: write 20 with same-cycle pop (10 leaves, 20 enters)
        step(1'b1, 1, 8'd20, 2'b10, 1'b1);
        check("wp_ovf",   32'(bus.o_overflow), 32'h0);
        check("wp_free1", 32'(bus.o_free[1]), 32'h0);
        check("wp_head1", 32'(bus.o_data[1].id), 32'd11);

        // Full VC1: write 15 without pop is dropped
        step(1'b1, 1, 8'd15, 2'b00, 1'b0);
        check("ovf_set",   32'(bus.o_overflow), 32'h1);
        check("ovf_free1", 32'(bus.o_free[1]), 32'h0);
        check("ovf_head1", 32'(bus.o_data[1].id), 32'd11);

        // Drain VC1: 11,12,13,14,20 via monitor
        for (int i = 0; i < 5; i++) step(1'b0, 0, 8'd0, 2'b10, 1'b0);
        check("drain_val1",  32'(bus.o_data_val[1]), 32'h0);
        check("drain_free1", 32'(bus.o_free[1]), DEPTH);
        check("vc0_intact",  32'(bus.o_free[0]), DEPTH - 3);

        // Pop on an empty VC is ignored
        step(1'b0, 0, 8'd0, 2'b10, 1'b0);
        check("empty_pop_free1", 32'(bus.o_free[1]), DEPTH);
        check("ovf_sticky",      32'(bus.o_overflow), 32'h1);

        // ce low: neither write nor pop takes effect
        ce = 1'b0;
        step(1'b1, 0, 8'd99, 2'b01, 1'b0);
        ce = 1'b1;
        check("ce_free0", 32'(bus.o_free[0]), DEPTH - 3);
        check("ce_head0", 32'(bus.o_data[0].id), 32'd1);

        // Drain VC0: 1,2,3
        for (int i = 0; i < 3; i++) step(1'b0, 0, 8'd0, 2'b01, 1'b0);
        check("drain_val0", 32'(bus.o_data_val), 32'h0);

        // Interleaved traffic with pops; 12 writes per VC wrap pointers twice
        do_reset();
        for (int v = 0; v < NUM_VC; v++) occ_m[v] = 0;
        ovf_m = 1'b0;
        for (int i = 0; i < 24; i++) begin
            automatic int         vc = (i % 2) ^ ((i / 6) % 2);
            automatic logic [1:0] en = {(i % 4) == 1, (i % 3) == 0};
            automatic logic [1:0] pe;
            automatic logic       acc;
            for (int v = 0; v < NUM_VC; v++) pe[v] = en[v] && (occ_m[v] > 0);
            acc = (occ_m[vc] < DEPTH) || pe[vc];
            if (!acc) ovf_m = 1'b1;
            for (int v = 0; v < NUM_VC; v++) begin
                occ_m[v] = occ_m[v] - int'(pe[v]);
                if (v == vc && acc) occ_m[v]++;
            end
            step(1'b1, vc, 8'(8'h40 + i), en, acc);
        end
        check("mix_free0", 32'(bus.o_free[0]), 32'(DEPTH - occ_m[0]));
        check("mix_free1", 32'(bus.o_free[1]), 32'(DEPTH - occ_m[1]));
        check("mix_ovf",   32'(bus.o_overflow), 32'(ovf_m));
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (occ_m[0] == 0 && occ_m[1] == 0) break;
            step(1'b0, 0, 8'd0, 2'b11, 1'b0);
            for (int v = 0; v < NUM_VC; v++) if (occ_m[v] > 0) occ_m[v]--;
        end
        check("mix_empty", 32'(bus.o_data_val), 32'h0);
        check("mix_q0", 32'(exp_q[0].size()), 32'h0);
        check("mix_q1", 32'(exp_q[1].size()), 32'h0);

        // Asynchronous reset mid-cycle discards queued packets at once
        step(1'b1, 0, 8'd50, 2'b00, 1'b1);
        step(1'b1, 0, 8'd51, 2'b00, 1'b1);
        check("pre_arst_free0", 32'(bus.o_free[0]), DEPTH - 2);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_val",   32'(bus.o_data_val), 32'h0);
        check("arst_free0", 32'(bus.o_free[0]), DEPTH);
        check("arst_free1", 32'(bus.o_free[1]), DEPTH);
        for (int v = 0; v < NUM_VC; v++) exp_q[v].delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Empty VC0: write id7 with a same-cycle pop request
        bus.i_data_val = 1'b1;
        bus.i_vc       = 1'b0;
        bus.i_data     = {8'd7, 8'hA5, 8'd7};
        bus.i_en       = 2'b01;
        exp_q[0].push_back(8'd7);
        #2;
`ifdef FIFO_VC_BYPASS_EN
        check("byp_val0",  32'(bus.o_data_val[0]), 32'h1);
        check("byp_head0", 32'(bus.o_data[0].id), 32'd7);
`else
        check("nobyp_val0", 32'(bus.o_data_val[0]), 32'h0);
`endif
        @(posedge clk);
        #1;
        bus.i_data_val = 1'b0;
        bus.i_en       = '0;
`ifdef FIFO_VC_BYPASS_EN
        check("byp_free0",  32'(bus.o_free[0]), DEPTH);
        check("byp_after0", 32'(bus.o_data_val[0]), 32'h0);
`else
        check("nobyp_free0", 32'(bus.o_free[0]), DEPTH - 1);
        check("nobyp_head0", 32'(bus.o_data[0].id), 32'd7);
        step(1'b0, 0, 8'd0, 2'b01, 1'b0);
        check("nobyp_drain", 32'(bus.o_free[0]), DEPTH);
`endif

        check("end_q0", 32'(exp_q[0].size()), 32'h0);
        check("end_q1", 32'(exp_q[1].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
